serial_adder: RTL and testbench

// - Bit-serial add/subtract unit built on the existing Full_Adder cell (ports a, b, cin, sum, cout).
// - Latches two WIDTH-bit operands and feeds one bit pair per clock, LSB first, through a single

---
 rtl/serial_adder_if.sv | 46 ++++
 rtl/serial_adder.sv | 169 ++++++++++++++++
 tb/tb_serial_adder.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle between a requester and the bit-serial adder.
// Latency: none; plain wires grouped for port hygiene.
// Backpressure: none; the requester watches busy/done (start is ignored while busy).
//
// Signals:
//   start, op_sub, a, b, cin   requester -> adder
//   busy, done, sum, cout      adder -> requester
//   ovf, zero                  adder -> requester, only with SERIAL_ADDER_FLAGS_EN
// Optional feature macro: SERIAL_ADDER_FLAGS_EN
interface serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_FLAGS_EN
  logic             ovf;
  logic             zero;

  modport master (
    output start, op_sub, a, b, cin,
    input  busy, done, sum, cout, ovf, zero
  );

  modport slave (
    input  start, op_sub, a, b, cin,
    output busy, done, sum, cout, ovf, zero
  );
`else
  modport master (
    output start, op_sub, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, op_sub, a, b, cin,
    output busy, done, sum, cout
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract, one bit pair per clock LSB first through one Full_Adder.
// Latency: WIDTH+1 edges from accepted start to done visible; done is a one-cycle pulse.
// Backpressure: none; start is ignored while busy, accepted again in the done cycle.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     serial_adder_if.slave: start/op_sub/a/b/cin in, busy/done/sum/cout out
//           (plus ovf/zero when SERIAL_ADDER_FLAGS_EN is defined)
// Optional feature macro: SERIAL_ADDER_FLAGS_EN (signed-overflow and zero flags)

// Existing one-bit full adder cell.
module Full_Adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic             carry_q,  carry_d;
  logic             cout_q,   cout_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
`ifdef SERIAL_ADDER_FLAGS_EN
  logic             ovf_q,    ovf_d;
  logic             zero_q,   zero_d;
`endif

  logic             fa_sum;
  logic             fa_cout;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] result_w;

  Full_Adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign accept   = bus.start && (state_q != RUN);
  assign last_bit = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
  // Shift register contents after this edge; on the last bit this is the finished result.
  assign result_w = {fa_sum, res_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDER_FLAGS_EN
    ovf_d    = ovf_q;
    zero_d   = zero_q;
`endif

    if (accept) begin
      // Subtract is folded in at capture time (b inverted, carry seeded to 1), so the
      // operation type never needs to be consulted again during RUN.
      state_d  = RUN;
      a_sh_d   = bus.a;
      b_sh_d   = bus.op_sub ? ~bus.b : bus.b;
      carry_d  = bus.op_sub ? 1'b1 : bus.cin;
      cnt_d    = '0;
      res_sh_d = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
          res_sh_d = result_w;
          carry_d  = fa_cout;
          if (last_bit) begin
            state_d = DONE;
            sum_d   = result_w;
            cout_d  = fa_cout;
`ifdef SERIAL_ADDER_FLAGS_EN
            // carry_q is the carry into the MSB while the MSB is being processed.
            ovf_d   = carry_q ^ fa_cout;
            zero_d  = (result_w == '0);
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DONE:    state_d = IDLE;
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_ADDER_FLAGS_EN
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SERIAL_ADDER_FLAGS_EN
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_FLAGS_EN
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized scoreboard bench for serial_adder (WIDTH=8).
// Stimulus pushes arithmetic expectations; a negedge monitor pops them on every done pulse
// and also checks that sum/cout only ever move on a done cycle.
module tb_serial_adder;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   push_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Plain integer arithmetic reference: unsigned for sum/cout, signed range for overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t e;
    int   ua, ub, sa, sb, r, sr;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    if (sub) begin
      r      = ua - ub;
      sr     = sa - sb;
      e.cout = (ua >= ub);
    end else begin
      r      = ua + ub + int'(cin);
      sr     = sa + sb + int'(cin);
      e.cout = (r >= (1 << W));
    end
    e.sum  = r[W-1:0];
    e.ovf  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    e.zero = (e.sum == '0);
    return e;
  endfunction

  // Monitor / scoreboard.
  logic [W-1:0] prev_sum  = '0;
  logic         prev_cout = 1'b0;
  logic         prev_rst  = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && prev_rst && !bus.done) begin
      chk("hold_sum", 32'(bus.sum), 32'(prev_sum));
      chk("hold_cout", 32'(bus.cout), 32'(prev_cout));
    end
    if (rst_n && bus.done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done required=no_done t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("sum", 32'(bus.sum), 32'(e.sum));
        chk("cout", 32'(bus.cout), 32'(e.cout));
`ifdef SERIAL_ADDER_FLAGS_EN
        chk("ovf", 32'(bus.ovf), 32'(e.ovf));
        chk("zero", 32'(bus.zero), 32'(e.zero));
`endif
      end
    end
    prev_sum  = bus.sum;
    prev_cout = bus.cout;
    prev_rst  = rst_n;
  end

  // Called just after a negedge with the DUT in IDLE or DONE; returns at the done negedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    bus.a      = a;
    bus.b      = b;
    bus.cin    = cin;
    bus.op_sub = sub;
    bus.start  = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(a, b, cin, sub));
    push_cnt++;
    #1;
    bus.start  = 1'b0;
    bus.a      = W'($urandom);
    bus.b      = W'($urandom);
    bus.cin    = 1'($urandom);
    bus.op_sub = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("busy_run", 32'(bus.busy), 32'd1);
      chk("done_run", 32'(bus.done), 32'd0);
    end
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("busy_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int d0;
    logic [W-1:0] ra, rb;
    logic [W-1:0] corner [4];
    corner[0] = 8'h00; corner[1] = 8'hFF; corner[2] = 8'h7F; corner[3] = 8'h80;

    bus.start  = 1'b0;
    bus.op_sub = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    bus.cin    = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADDER_FLAGS_EN
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    issue(8'h0F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    issue(8'h7F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    issue(8'h05, 8'h07, 1'b1, 1'b1);
    @(negedge clk);

    // start held through RUN with changing operands, then accepted again in the DONE cycle.
    d0 = done_cnt;
    bus.a = 8'h33; bus.b = 8'h44; bus.cin = 1'b1; bus.op_sub = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(8'h33, 8'h44, 1'b1, 1'b0));
    push_cnt++;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("held_busy", 32'(bus.busy), 32'd1);
      bus.a      = W'($urandom);
      bus.b      = W'($urandom);
      bus.op_sub = 1'($urandom);
      bus.cin    = 1'($urandom);
    end
    @(negedge clk);
    chk("held_done1", 32'(bus.done), 32'd1);
    bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0; bus.op_sub = 1'b0;
    @(posedge clk);
    exp_q.push_back(model(8'h10, 8'h20, 1'b0, 1'b0));
    push_cnt++;
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("b2b_busy", 32'(bus.busy), 32'd1);
      chk("b2b_sum_held", 32'(bus.sum), 32'h78);
    end
    @(negedge clk);
    chk("b2b_done2", 32'(bus.done), 32'd1);
    @(negedge clk);
    chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);

    // Abort mid-RUN.
    bus.a = 8'h0F; bus.b = 8'h01; bus.cin = 1'b0; bus.op_sub = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_sum", 32'(bus.sum), 32'd0);
    chk("abort_cout", 32'(bus.cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(8'h0F, 8'h01, 1'b0, 1'b0);

    // Randomized ops with random gaps (gap 0 = back-to-back).
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      issue(ra, rb, 1'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_total", 32'(done_cnt), 32'(push_cnt));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
